// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: port payload struct and read-return owner.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DM_ADDRESS = 9;
    localparam int unsigned F3_W       = 3;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DBG
    } mem_owner_t;

    typedef struct packed {
        logic                  we;
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [F3_W-1:0]       funct3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter; sat_c tells the arbiter the waiting port must be forced in.
module starve_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat_c
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < LIM)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sat_c = (cnt >= LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has fixed priority, debug port is forced in after
// STARVE_MAX lost cycles. Read data returns one cycle after grant to the recorded owner.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [F3_W-1:0]       core_funct3,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [F3_W-1:0]       dbg_funct3,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [F3_W-1:0]       mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    mem_req_t   core_pl;
    mem_req_t   dbg_pl;
    mem_req_t   sel_pl;
    mem_owner_t rd_owner;
    mem_owner_t rd_owner_nxt;
    logic       force_dbg;

    assign core_pl = '{we: core_we, addr: core_addr, wdata: core_wdata, funct3: core_funct3};
    assign dbg_pl  = '{we: dbg_we,  addr: dbg_addr,  wdata: dbg_wdata,  funct3: dbg_funct3};

    starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (dbg_req & core_gnt),
        .clr   (dbg_gnt | ~dbg_req),
        .sat_c (force_dbg)
    );

    // Grant and memory mux; everything is held quiet while reset is high.
    always_comb begin
        dbg_gnt  = 1'b0;
        core_gnt = 1'b0;
        sel_pl   = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        if (!reset) begin
            dbg_gnt  = dbg_req & (~core_req | force_dbg);
            core_gnt = core_req & ~dbg_gnt;
        end
        if (core_gnt) begin
            sel_pl = core_pl;
            mem_rd = ~core_pl.we;
            mem_wr = core_pl.we;
        end else if (dbg_gnt) begin
            sel_pl = dbg_pl;
            mem_rd = ~dbg_pl.we;
            mem_wr = dbg_pl.we;
        end
    end

    assign mem_addr   = sel_pl.addr;
    assign mem_wdata  = sel_pl.wdata;
    assign mem_funct3 = sel_pl.funct3;
    assign core_stall = core_req & ~core_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // Owner lives exactly one cycle: only the cycle after a read grant returns data.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (core_gnt && !core_we) begin
            rd_owner_nxt = OWN_CORE;
        end else if (dbg_gnt && !dbg_we) begin
            rd_owner_nxt = OWN_DBG;
        end
    end

    assign core_rvalid = (rd_owner == OWN_CORE);
    assign dbg_rvalid  = (rd_owner == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (core port) and a debug/loader port (dbg port) used by benches and the program loader.
- Sits between the datapath's EX/MEM-stage memory signals and `datamemory`.
- Arbitration is fixed-priority to the core, with a starvation counter that forces a debug grant.
- Produces a stall request that freezes the pipeline while the core is not granted.

Parameters:
- DATA_W, 32, data width.
- DM_ADDRESS, 9, data-memory byte address width.
- STARVE_MAX, 4, number of consecutive cycles dbg may wait while core is granted before dbg is forced; range 1..15.
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- core_req, input, 1, core access request (MemRead|MemWrite of MEM stage).
- core_we, input, 1, 1 = write, 0 = read.
- core_addr, input, DM_ADDRESS, byte address.
- core_wdata, input, DATA_W, store data.
- core_funct3, input, 3, access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- core_gnt, output, 1, core access issued this cycle.
- core_rvalid, output, 1, core read data valid.
- core_rdata, output, DATA_W, core read data.
- core_stall, output, 1, core_req & ~core_gnt; freezes the pipeline.
- dbg_req, input, 1, debug access request.
- dbg_we, input, 1, 1 = write, 0 = read.
- dbg_addr, input, DM_ADDRESS, byte address.
- dbg_wdata, input, DATA_W, store data.
- dbg_funct3, input, 3, access size.
- dbg_gnt, output, 1, debug access issued this cycle.
- dbg_rvalid, output, 1, debug read data valid.
- dbg_rdata, output, DATA_W, debug read data.
- mem_rd, output, 1, memory read enable.
- mem_wr, output, 1, memory write enable.
- mem_addr, output, DM_ADDRESS, memory address.
- mem_wdata, output, DATA_W, memory write data.
- mem_funct3, output, 3, memory access size.
- mem_rdata, input, DATA_W, memory read data, valid one cycle after mem_rd.

Behaviour:
- Grant is combinational from the current requests and registered state. Exactly one of core_gnt/dbg_gnt may be high in a cycle (one-hot or zero).
- Grant rule:
  - dbg_gnt = dbg_req & (~core_req | force_dbg), where force_dbg = (starve_cnt >= STARVE_MAX).
  - core_gnt = core_req & ~dbg_gnt.
- Memory mux: mem_* driven from the granted port. When nothing is granted: mem_rd = mem_wr = 0, and mem_addr, mem_wdata and mem_funct3 hold 0.
- Writes complete in the grant cycle. Reads: mem_rdata is sampled one cycle after grant.
- Read-return tracking: registered rd_owner (NONE/CORE/DBG) is set on the grant of a read, otherwise NONE.
  - Cycle after a read grant: the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata = 0.
- A new grant may be issued in the same cycle a previous read returns (back-to-back, full throughput, one access per cycle).
- Starvation counter starve_cnt (CNT_W bits):
  - Increments when dbg_req & core_gnt.
  - Clears when dbg_gnt or ~dbg_req.
  - Saturates at STARVE_MAX.
- After a forced dbg grant, the core gets the next cycle (the counter is at 0). Core stall is therefore at most 1 cycle per STARVE_MAX+1.
- Requesters hold req, we, addr, wdata and funct3 stable until their gnt. Dropping req before gnt is allowed: that request is abandoned, with no side effect.
- Reset (asynchronous, any cycle):
  - starve_cnt = 0, rd_owner = NONE.
  - All rvalid = 0, all rdata = 0.
  - Grants and mem_* are forced to 0 while reset is high.
  - A read in flight at reset is discarded: no rvalid after reset deasserts.
- Simultaneous core and dbg request with counter below STARVE_MAX: core wins; dbg waits and the counter increments.
- Simultaneous requests to the same address on the same cycle: only the granted access occurs; the loser reissues later and sees the winner's write.

Decomposition:
- Pipe_Buf_Reg_PKG gains:
  - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} mem_owner_t.
  - struct mem_req_t {we, addr, wdata, funct3}, used for both ports and the mux.
- One natural sub-module: starve_counter (saturating up-counter with clear, parameterised width/limit).
- The mux and owner register stay in the top level.

Test Plan:
- Reset then core read: core_req=1, core_we=0, core_addr=0x010, mem_rdata=0xDEADBEEF → core_gnt=1 in the same cycle, mem_rd=1; the next cycle core_rvalid=1 with core_rdata=0xDEADBEEF, and dbg_rvalid=0.
- dbg write alone: dbg_req=1, dbg_we=1, addr=0x020, wdata=0x12345678, funct3=3'b010 → dbg_gnt=1 and mem_wr=1 with matching mem_addr/mem_wdata/mem_funct3; core_stall=0.
- Contention, STARVE_MAX=4: core_req and dbg_req both held high → core_gnt on cycles 0-3, dbg_gnt on cycle 4 with core_stall=1, core_gnt on cycle 5, repeating every 5 cycles.
- Back-to-back reads: core read 0x000 at cycle 0, dbg read 0x004 at cycle 1 (core idle) → core_rvalid at cycle 1 and dbg_rvalid at cycle 2, each carrying the correct mem_rdata, never swapped.
- Reset mid-read: core read granted at cycle 0, reset asserted asynchronously before edge 1 and released at cycle 2 → core_rvalid stays 0 throughout; starve_cnt=0; mem_rd=0 while reset is high.
- Abandoned request: dbg_req high for 2 cycles under core contention, then dropped → no dbg_gnt, starve_cnt returns to 0, no mem_wr from dbg.
